// File: rtl/data_port_pkg.sv
// Shared encodings for the CPU data-side port and its downstream targets.
package data_port_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int CH_UNCACHED = 0;
    localparam int CH_DCACHE   = 1;

endpackage

// File: rtl/inflight_tracker.sv
// Tracks accepted-but-unanswered transactions, the channel that owns them,
// and flags responses arriving from a channel that has nothing in flight.
module inflight_tracker
    import data_port_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int MAX_OUT = 4,
    parameter int SW      = $clog2(NCH),
    parameter int CW      = $clog2(MAX_OUT + 1)
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           cpu_req,
    input  logic [SW-1:0]  cpu_sel,
    input  logic           sel_addr_ok,
    input  logic [NCH-1:0] dn_data_ok,
    output logic           allow,
    output logic           cpu_addr_ok,
    output logic           cpu_data_ok,
    output logic [SW-1:0]  cur_ch,
    output logic [CW-1:0]  cnt,
    output logic           busy,
    output logic           err_stray
);

    logic [CW-1:0]  cnt_q, cnt_d;
    logic [SW-1:0]  cur_ch_q, cur_ch_d;
    logic           busy_q, busy_d;
    logic           err_q, err_d;
    logic           accept;
    logic           resp;
    logic [NCH-1:0] own_mask;

    always_comb begin
        allow       = (cnt_q < CW'(MAX_OUT)) &&
                      (cnt_q == '0 || cpu_sel == cur_ch_q);
        cpu_addr_ok = allow & sel_addr_ok;
        accept      = cpu_req & cpu_addr_ok;
        resp        = (cnt_q != '0) & dn_data_ok[cur_ch_q];
        cpu_data_ok = resp;

        // Only the owning channel may answer, and only while something is in flight.
        own_mask = '0;
        if (cnt_q != '0) begin
            own_mask = NCH'(1) << cur_ch_q;
        end

        cnt_d    = cnt_q;
        cur_ch_d = cur_ch_q;
        if (accept) begin
            cur_ch_d = cpu_sel;
        end
        if (accept && !resp) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!accept && resp) begin
            cnt_d = cnt_q - CW'(1);
        end

        busy_d = (cnt_d != '0);
        err_d  = err_q | (|(dn_data_ok & ~own_mask));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q    <= '0;
            cur_ch_q <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            cur_ch_q <= cur_ch_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign cur_ch    = cur_ch_q;
    assign cnt       = cnt_q;
    assign busy      = busy_q;
    assign err_stray = err_q;

endmodule

// File: rtl/data_port_router.sv
// N-channel router for the CPU data-side sram-like port with in-order
// response tracking, so the select may change while requests are in flight.
module data_port_router
    import data_port_pkg::*;
#(
    parameter int             NCH        = 2,
    parameter int             AW         = 32,
    parameter int             DW         = 32,
    parameter int             MAX_OUT    = 4,
    parameter logic [NCH-1:0] FORCE_WORD = NCH'(2'b10),
    parameter int             SW         = $clog2(NCH),
    parameter int             CW         = $clog2(MAX_OUT + 1)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [1:0]        cpu_size,
    input  logic [AW-1:0]     cpu_addr,
    input  logic [DW-1:0]     cpu_wdata,
    input  logic [SW-1:0]     cpu_sel,
    output logic              cpu_addr_ok,
    output logic              cpu_data_ok,
    output logic [DW-1:0]     cpu_rdata,
    output logic [NCH-1:0]    dn_req,
    output logic [NCH-1:0]    dn_wr,
    output logic [2*NCH-1:0]  dn_size,
    output logic [AW*NCH-1:0] dn_addr,
    output logic [DW*NCH-1:0] dn_wdata,
    input  logic [DW*NCH-1:0] dn_rdata,
    input  logic [NCH-1:0]    dn_addr_ok,
    input  logic [NCH-1:0]    dn_data_ok,
    output logic [CW-1:0]     outstanding,
    output logic              busy,
    output logic              err_stray
);

    logic          allow;
    logic          sel_addr_ok;
    logic [SW-1:0] cur_ch;

    assign sel_addr_ok = dn_addr_ok[cpu_sel];

    inflight_tracker #(
        .NCH     (NCH),
        .MAX_OUT (MAX_OUT),
        .SW      (SW),
        .CW      (CW)
    ) u_tracker (
        .clk         (clk),
        .resetn      (resetn),
        .cpu_req     (cpu_req),
        .cpu_sel     (cpu_sel),
        .sel_addr_ok (sel_addr_ok),
        .dn_data_ok  (dn_data_ok),
        .allow       (allow),
        .cpu_addr_ok (cpu_addr_ok),
        .cpu_data_ok (cpu_data_ok),
        .cur_ch      (cur_ch),
        .cnt         (outstanding),
        .busy        (busy),
        .err_stray   (err_stray)
    );

    // Request fields are broadcast; only the channel seeing dn_req acts.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign dn_req[i]              = cpu_req & allow & (cpu_sel == SW'(i));
        assign dn_wr[i]               = cpu_wr;
        assign dn_size[2*i +: 2]      = FORCE_WORD[i] ? SZ_WORD : cpu_size;
        assign dn_addr[AW*i +: AW]    = cpu_addr;
        assign dn_wdata[DW*i +: DW]   = cpu_wdata;
    end

    always_comb begin
        cpu_rdata = dn_rdata[int'(cur_ch)*DW +: DW];
    end

endmodule

// File: tb/tb_data_port_router.sv
// Directed bench for data_port_router: routing, size forcing, channel
// switch blocking, saturation, concurrent accept/response, stray and reset.
module tb_data_port_router;
    import data_port_pkg::*;

    localparam int NCH = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MAX_OUT = 4;
    localparam int SW = 1;
    localparam int CW = 3;

    logic              clk = 1'b0;
    logic              resetn;
    logic              cpu_req;
    logic              cpu_wr;
    logic [1:0]        cpu_size;
    logic [AW-1:0]     cpu_addr;
    logic [DW-1:0]     cpu_wdata;
    logic [SW-1:0]     cpu_sel;
    logic              cpu_addr_ok;
    logic              cpu_data_ok;
    logic [DW-1:0]     cpu_rdata;
    logic [NCH-1:0]    dn_req;
    logic [NCH-1:0]    dn_wr;
    logic [2*NCH-1:0]  dn_size;
    logic [AW*NCH-1:0] dn_addr;
    logic [DW*NCH-1:0] dn_wdata;
    logic [DW*NCH-1:0] dn_rdata;
    logic [NCH-1:0]    dn_addr_ok;
    logic [NCH-1:0]    dn_data_ok;
    logic [CW-1:0]     outstanding;
    logic              busy;
    logic              err_stray;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    data_port_router #(
        .NCH        (NCH),
        .AW         (AW),
        .DW         (DW),
        .MAX_OUT    (MAX_OUT),
        .FORCE_WORD (2'b10)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .cpu_req     (cpu_req),
        .cpu_wr      (cpu_wr),
        .cpu_size    (cpu_size),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_sel     (cpu_sel),
        .cpu_addr_ok (cpu_addr_ok),
        .cpu_data_ok (cpu_data_ok),
        .cpu_rdata   (cpu_rdata),
        .dn_req      (dn_req),
        .dn_wr       (dn_wr),
        .dn_size     (dn_size),
        .dn_addr     (dn_addr),
        .dn_wdata    (dn_wdata),
        .dn_rdata    (dn_rdata),
        .dn_addr_ok  (dn_addr_ok),
        .dn_data_ok  (dn_data_ok),
        .outstanding (outstanding),
        .busy        (busy),
        .err_stray   (err_stray)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    // Advance one clock; inputs are driven 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        resetn     = 1'b0;
        cpu_req    = 1'b0;
        cpu_wr     = 1'b0;
        cpu_size   = SZ_WORD;
        cpu_addr   = '0;
        cpu_wdata  = '0;
        cpu_sel    = '0;
        dn_rdata   = '0;
        dn_addr_ok = 2'b11;
        dn_data_ok = 2'b00;
        #12;
        chk("rst_out", 64'(outstanding), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_err", 64'(err_stray), 0);
        step();
        resetn = 1'b1;
        step();

        // single uncached read
        cpu_req  = 1'b1;
        cpu_sel  = 1'(CH_UNCACHED);
        cpu_addr = 32'hBFAF_0000;
        settle();
        chk("t1_aok", 64'(cpu_addr_ok), 1);
        chk("t1_req", 64'(dn_req), 64'b01);
        chk("t1_addr0", 64'(dn_addr[31:0]), 64'hBFAF_0000);
        step();
        cpu_req = 1'b0;
        chk("t1_out1", 64'(outstanding), 1);
        chk("t1_busy1", 64'(busy), 1);
        step();
        dn_data_ok = 2'b01;
        dn_rdata   = {32'hDEAD_BEEF, 32'h1234_5678};
        settle();
        chk("t1_dok", 64'(cpu_data_ok), 1);
        chk("t1_rdata", 64'(cpu_rdata), 64'h1234_5678);
        step();
        dn_data_ok = 2'b00;
        chk("t1_out0", 64'(outstanding), 0);
        chk("t1_busy0", 64'(busy), 0);

        // force-word and broadcast
        cpu_sel   = 1'(CH_DCACHE);
        cpu_size  = SZ_BYTE;
        cpu_wr    = 1'b1;
        cpu_wdata = 32'hA5A5_0F0F;
        settle();
        chk("t2_size1", 64'(dn_size[3:2]), 64'(SZ_WORD));
        chk("t2_wr", 64'(dn_wr), 64'b11);
        chk("t2_wd1", 64'(dn_wdata[63:32]), 64'hA5A5_0F0F);
        cpu_sel = 1'(CH_UNCACHED);
        settle();
        chk("t2_size0", 64'(dn_size[1:0]), 64'(SZ_BYTE));
        chk("t2_noreq", 64'(dn_req), 0);
        cpu_wr   = 1'b0;
        cpu_size = SZ_WORD;
        step();

        // channel switch blocked by two ch1 reads
        cpu_req = 1'b1;
        cpu_sel = 1'(CH_DCACHE);
        step();
        step();
        chk("t3_out2", 64'(outstanding), 2);
        cpu_sel = 1'(CH_UNCACHED);
        settle();
        chk("t3_aok_blk", 64'(cpu_addr_ok), 0);
        chk("t3_req_blk", 64'(dn_req), 0);
        dn_data_ok = 2'b10;
        dn_rdata   = {32'h0000_0111, 32'h0};
        settle();
        chk("t3_dok_a", 64'(cpu_data_ok), 1);
        chk("t3_rd_a", 64'(cpu_rdata), 64'h111);
        step();
        chk("t3_out1", 64'(outstanding), 1);
        chk("t3_aok_blk1", 64'(cpu_addr_ok), 0);
        step();
        dn_data_ok = 2'b00;
        chk("t3_out0", 64'(outstanding), 0);
        settle();
        chk("t3_aok", 64'(cpu_addr_ok), 1);
        chk("t3_req", 64'(dn_req), 64'b01);
        step();
        cpu_req = 1'b0;
        chk("t3_out_new", 64'(outstanding), 1);
        dn_data_ok = 2'b01;
        step();
        dn_data_ok = 2'b00;
        chk("t3_drain", 64'(outstanding), 0);

        // saturation at MAX_OUT
        cpu_req = 1'b1;
        cpu_sel = 1'(CH_DCACHE);
        repeat (4) step();
        chk("t4_out4", 64'(outstanding), 4);
        settle();
        chk("t4_aok_full", 64'(cpu_addr_ok), 0);
        chk("t4_req_full", 64'(dn_req), 0);
        dn_data_ok = 2'b10;
        settle();
        chk("t4_dok", 64'(cpu_data_ok), 1);
        chk("t4_aok_resp", 64'(cpu_addr_ok), 0);
        step();
        dn_data_ok = 2'b00;
        chk("t4_out3", 64'(outstanding), 3);
        settle();
        chk("t4_aok_next", 64'(cpu_addr_ok), 1);
        step();
        chk("t4_out4b", 64'(outstanding), 4);

        // drain to two, then accept and respond together
        cpu_req    = 1'b0;
        dn_data_ok = 2'b10;
        step();
        step();
        chk("t5_out2", 64'(outstanding), 2);
        cpu_req = 1'b1;
        settle();
        chk("t5_dok", 64'(cpu_data_ok), 1);
        chk("t5_aok", 64'(cpu_addr_ok), 1);
        step();
        cpu_req = 1'b0;
        chk("t5_hold2", 64'(outstanding), 2);
        step();
        step();
        dn_data_ok = 2'b00;
        chk("t5_drain", 64'(outstanding), 0);
        chk("t5_noerr", 64'(err_stray), 0);

        // stray response at cnt 0
        dn_data_ok = 2'b01;
        settle();
        chk("t6_dok_stray", 64'(cpu_data_ok), 0);
        step();
        dn_data_ok = 2'b00;
        chk("t6_err", 64'(err_stray), 1);
        step();
        chk("t6_sticky", 64'(err_stray), 1);

        // reset mid-burst
        cpu_req = 1'b1;
        cpu_sel = 1'(CH_UNCACHED);
        repeat (3) step();
        cpu_req = 1'b0;
        chk("t6_out3", 64'(outstanding), 3);
        #2;
        resetn = 1'b0;
        #1;
        chk("t6_rst_out", 64'(outstanding), 0);
        chk("t6_rst_busy", 64'(busy), 0);
        chk("t6_rst_err", 64'(err_stray), 0);
        step();
        resetn     = 1'b1;
        dn_data_ok = 2'b01;
        settle();
        chk("t6_late_dok", 64'(cpu_data_ok), 0);
        step();
        dn_data_ok = 2'b00;
        chk("t6_late_err", 64'(err_stray), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
